riscv_fetch_unit: RTL and testbench
===================================

// Module: riscv_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation core. It replaces the
//  "Instr in / PC out" boundary with a request/grant memory interface and an in-order
//  prefetch queue of DEPTH entries. It delivers {pc, instr} pairs to decode over a
//  valid/ready handshake and flushes on branch/jump redirect.
// PARAMETERS
//  XLEN      32   data/address width (32 or 64)
//  DEPTH     4    prefetch queue entries; power of 2, >=2; also caps outstanding requests
//  RESET_PC  '0   first fetch address after reset; bits [1:0] must be 0
// PORTS
//  clk             in   1     clock, rising edge
//  reset           in   1     asynchronous, active-high reset
//  imem_req        out  1     fetch request valid
//  imem_addr       out  XLEN  fetch address, word aligned
//  imem_gnt        in   1     request accepted this cycle (imem_req & imem_gnt = issue)
//  imem_rvalid     in   1     response valid; responses in issue order, >=1 cycle after grant
//  imem_rdata      in   32    instruction word
//  redirect_valid  in   1     flush and restart fetch (taken branch/jump)
//  redirect_pc     in   XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
//  instr_valid     out  1     {instr_pc, instr} valid to decode
//  instr_ready     in   1     decode accepts (instr_valid & instr_ready = pop)
//  instr           out  32    instruction word
//  instr_pc        out  XLEN  PC of instr
// BEHAVIOUR
//  - Reset (async): fetch_pc=resp_pc=RESET_PC, queue empty, outstanding=discard=0;
//    imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC.
//  - Issue: imem_req = !redirect_valid && (count + outstanding) < DEPTH.
//    imem_addr = fetch_pc. On issue, fetch_pc += 4 (wraps mod 2^XLEN) and outstanding++.
//  - Response: each imem_rvalid decrements outstanding. If discard>0, the response is
//    dropped and discard-- applies. Otherwise it is pushed as {resp_pc, imem_rdata} and
//    resp_pc += 4. Overflow is impossible by the issue budget; the fifo asserts on it.
//  - Output: instr_valid = !empty && !redirect_valid. instr, instr_pc show the head entry.
//    Pop occurs only on instr_valid & instr_ready.
//  - Latency: with a zero-wait memory (gnt=1, rvalid 1 cycle after grant), first
//    instr_valid comes 2 cycles after reset deassertion. Steady state is 1 instr/cycle
//    with ready held high.
//  - Redirect (cycle R): queue is flushed; no issue and no pop in R.
//    - discard <= outstanding_next, where outstanding_next already accounts for an
//      rvalid landing in R; that response is dropped.
//    - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
//    - Issue resumes in R+1.
//  - Simultaneous push+pop at count==DEPTH-1 or DEPTH: both take effect; count unchanged.
//  - Simultaneous issue and rvalid: outstanding unchanged.
//  - reset mid-transfer: all state cleared at once. The memory side must also be reset,
//    because responses arriving after reset are not tracked.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetched [31:0] and perf_flushes [31:0].
//    - perf_fetched counts pops; perf_flushes counts redirect cycles.
//    - Both counters saturate at 2^32-1 and reset to 0.
//  Not defined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  riscv_pkg contents:
//    - fetch_entry_t: packed struct {logic [XLEN-1:0] pc; logic [31:0] instr;}.
//    - INSTR_BYTES=4.
//    - function-computed pointer width PTR_W=$clog2(DEPTH).
//  Sub-module riscv_fetch_fifo: DEPTH-entry synchronous fifo of fetch_entry_t.
//    - Ports: push, pop, flush, head, count, full, empty.
//    - flush has priority over push/pop.
//  Top level holds fetch_pc, resp_pc, outstanding and discard counters
//  ($clog2(DEPTH+1) bits), plus the optional perf counters.
// TESTING
//  1 Reset, gnt=1, rvalid 1-cycle, ready=1 -> instr_pc 0x0,0x4,0x8,... one per cycle
//    from cycle 2; instr equals memory model data.
//  2 ready=0 for 20 cycles -> exactly DEPTH=4 issues total; count+outstanding never >4.
//    Release ready -> in-order drain, no loss or duplication.
//  3 3 requests outstanding (rvalid latency 3), redirect_pc=0x100 -> 3 stale responses
//    dropped; next instr_pc=0x100.
//  4 Redirect in same cycle as rvalid and pop -> instr_valid=0 that cycle, response
//    dropped, queue empty in R+1, imem_addr=redirect_pc.
//  5 redirect_pc=0x203 -> fetch from 0x200. Start at RESET_PC=0xFFFFFFFC, XLEN=32 ->
//    second fetch at 0x0.
//  6 Random gnt/rvalid latency 1-5, random ready/redirect, 10k cycles vs reference model
//    -> stream matches. With FETCH_PERF_CNT_EN, perf counters equal scoreboard totals.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
//
// Contents:
//   XLEN_MAX      widest supported address width; fetch entries are sized for it so the
//                 same entry type serves both XLEN=32 and XLEN=64 builds
//   INSTR_BYTES   bytes per instruction word (fetch PC increment)
//   fetch_entry_t {pc, instr} pair held in the prefetch queue
//   ptr_width()   pointer width for a power-of-two queue depth (PTR_W)
package riscv_pkg;

    localparam int unsigned XLEN_MAX    = 64;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

    // Clamped to 1 so a pointer always has at least one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// In-order prefetch queue of fetch_entry_t, DEPTH entries (power of two).
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head entry (ignored when empty)
//   flush_i        empty the queue; wins over push_i/pop_i
//   head_o         head entry (contents undefined when empty_o)
//   count_o        number of valid entries
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                push_i,
    input  fetch_entry_t                        push_data_i,
    input  logic                                pop_i,
    input  logic                                flush_i,
    output fetch_entry_t                        head_o,
    output logic [riscv_pkg::ptr_width(DEPTH):0] count_o,
    output logic                                full_o,
    output logic                                empty_o
);

    localparam int unsigned PTR_W    = ptr_width(DEPTH);
    localparam int unsigned CNT_BITS = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    fetch_entry_t     mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_BITS'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Push at full is legal only together with a pop: the head is read out this cycle
    // and its slot (== wr_ptr) is rewritten at the edge.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // The fetch issue budget guarantees the queue never overflows.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: request/grant memory port, in-order prefetch queue and
// valid/ready delivery of {pc, instr} pairs to decode, with flush on redirect.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   imem_req_o        fetch request valid (issue = imem_req_o & imem_gnt_i)
//   imem_addr_o       word-aligned fetch address
//   imem_gnt_i        request accepted
//   imem_rvalid_i     response valid, in issue order
//   imem_rdata_i      instruction word of the response
//   redirect_valid_i  flush and restart fetch at redirect_pc_i (bits [1:0] ignored)
//   redirect_pc_i     new fetch PC
//   instr_valid_o     head entry valid to decode (pop = instr_valid_o & instr_ready_i)
//   instr_ready_i     decode accepts
//   instr_o           instruction word of the head entry
//   instr_pc_o        PC of the head entry
//   perf_fetched_o    (FETCH_PERF_CNT_EN only) saturating count of pops
//   perf_flushes_o    (FETCH_PERF_CNT_EN only) saturating count of redirect cycles
//
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_flushes_o
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             issue, push, pop;
    logic [XLEN-1:0]  redirect_pc_aligned;
    logic [SUM_W-1:0] in_flight;
    fetch_entry_t     push_entry, head_entry;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full, fifo_empty;
    logic             unused_fifo;

    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Queued entries plus requests still in flight never exceed DEPTH, so every response
    // has a guaranteed slot.
    assign in_flight  = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
    assign imem_req_o = !rst_i && !redirect_valid_i && (in_flight < SUM_W'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign issue = imem_req_o && imem_gnt_i;

    // Responses belonging to a flushed fetch stream are dropped while discard_q > 0.
    assign push = imem_rvalid_i && !redirect_valid_i && (discard_q == '0);

    assign instr_valid_o = !fifo_empty && !redirect_valid_i;
    assign pop = instr_valid_o && instr_ready_i;

    always_comb begin
        push_entry                = '0;
        push_entry.pc[XLEN-1:0]   = resp_pc_q;
        push_entry.instr          = imem_rdata_i;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({issue, imem_rvalid_i})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect_valid_i) begin
            // Everything still in flight after this cycle belongs to the old stream.
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
        end else begin
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
            if (issue) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (push)  resp_pc_d  = resp_pc_q + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid_i),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Upper PC bits are zero when XLEN < XLEN_MAX; full is implied by the issue budget.
    assign unused_fifo = ^head_entry.pc ^ fifo_full;

    // With an empty queue, show the PC the next response will carry (RESET_PC after reset).
    assign instr_o    = fifo_empty ? 32'h0 : head_entry.instr;
    assign instr_pc_o = fifo_empty ? resp_pc_q : head_entry.pc[XLEN-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flushes_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (pop && (perf_fetched_q != '1))
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect_valid_i && (perf_flushes_q != '1))
                perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_flushes_o = perf_flushes_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushes;
`endif

    riscv_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o   (perf_fetched),
        .perf_flushes_o   (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_fetch_pc, m_resp_pc, m_stream_pc;
    int          m_outst, m_discard;
    logic [31:0] m_q_pc[$];
    logic [31:0] m_q_ins[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc, n_issues, n_pops, n_flushes;

    // Sampled DUT outputs of the latest step
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fetch_pc = RST_PC; m_resp_pc = RST_PC; m_stream_pc = RST_PC;
        m_outst = 0; m_discard = 0;
        m_q_pc.delete(); m_q_ins.delete(); pend_addr.delete(); pend_due.delete();
        cyc = 0; n_issues = 0; n_pops = 0; n_flushes = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                        input bit gnt, input int lat);
        bit rv, exp_req, exp_valid, issue, pop;
        logic [31:0] rd;
        @(negedge clk);
        redirect_valid = redir; redirect_pc = rpc; instr_ready = rdy; imem_gnt = gnt;
        rv = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
        rd = rv ? memf(pend_addr[0]) : $urandom;
        imem_rvalid = rv; imem_rdata = rd;
        #1;
        exp_req   = !redir && ((m_q_pc.size() + m_outst) < 4);
        exp_valid = (m_q_pc.size() > 0) && !redir;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_pc = instr_pc; s_instr = instr;
        chk("imem_req", s_req, exp_req);
        chk("imem_addr", s_addr, m_fetch_pc);
        chk("instr_valid", s_valid, exp_valid);
        if (exp_valid && s_valid) begin
            chk("instr_pc", s_pc, m_q_pc[0]);
            chk("instr", s_instr, m_q_ins[0]);
        end
        issue = exp_req && gnt;
        pop   = exp_valid && rdy;
        if (pop) begin
            // Stream view: sequential PCs from the last redirect, data from memory.
            chk("stream_pc", s_pc, m_stream_pc);
            chk("stream_data", s_instr, memf(s_pc));
            m_stream_pc = m_stream_pc + 32'd4;
            void'(m_q_pc.pop_front()); void'(m_q_ins.pop_front());
            n_pops++;
        end
        if (redir) begin
            n_flushes++;
            m_q_pc.delete(); m_q_ins.delete();
            m_outst   = m_outst - int'(rv);
            m_discard = m_outst;
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_resp_pc  = {rpc[31:2], 2'b00};
            m_stream_pc = {rpc[31:2], 2'b00};
        end else begin
            if (issue) begin
                pend_addr.push_back(m_fetch_pc); pend_due.push_back(cyc + lat);
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_outst++; n_issues++;
            end
            if (rv) begin
                m_outst--;
                if (m_discard > 0) m_discard--;
                else begin
                    m_q_pc.push_back(m_resp_pc); m_q_ins.push_back(rd);
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end
        end
        if (rv) begin
            void'(pend_addr.pop_front()); void'(pend_due.pop_front());
        end
        cyc++;
    endtask

    task automatic quiesce();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    endtask

    // Run a zero-wait stream until the first delivered instruction and pin its PC.
    task automatic expect_first_pop(input string name, input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (s_valid) begin
                found = 1'b1;
                chk(name, s_pc, pc);
            end
        end
        chk({name, "_seen"}, found, 1'b1);
    endtask

    initial begin
        int base;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'hFFFF_FFF8);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait memory, ready high: first delivery two cycles after reset, PCs wrap.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (k == 0) begin
                chk("lat_req0", s_req, 1'b1);
                chk("lat_addr0", s_addr, 32'hFFFF_FFF8);
            end
            if (k == 1) chk("lat_valid1", s_valid, 1'b0);
            if (k == 2) begin
                chk("lat_valid2", s_valid, 1'b1);
                chk("lat_pc2", s_pc, 32'hFFFF_FFF8);
            end
            if (k == 4) chk("wrap_pc4", s_pc, 32'h0000_0000);
            if (k == 5) chk("wrap_pc5", s_pc, 32'h0000_0004);
        end

        // Decode stalled: exactly DEPTH issues, then an in-order drain.
        quiesce();
        base = n_issues;
        for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        chk("stall_issues", n_issues - base, 4);
        chk("stall_valid", s_valid, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1);

        // Three requests in flight (latency 3), redirect as the first response lands.
        quiesce();
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1);
        chk("redir3_valid", s_valid, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("redir3_addr", s_addr, 32'h0000_0100);
        expect_first_pop("redir3_pc", 32'h0000_0100);

        // Redirect together with an arriving response and a ready decode; low bits ignored.
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1);
        chk("redir4_valid", s_valid, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("redir4_addr", s_addr, 32'h0000_0200);
        chk("redir4_empty", s_valid, 1'b0);
        expect_first_pop("redir4_pc", 32'h0000_0200);

        // Randomised traffic against the model.
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, int'($urandom_range(1, 5)));
        end

`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        chk("perf_fetched", perf_fetched, n_pops);
        chk("perf_flushes", perf_flushes, n_flushes);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
